// File: rtl/receive_control_if.sv
// Byte-stream / packet-result bundle between a byte receiver and receive_control.
interface receive_control_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [63:0] data_out;
    logic        packet_valid;
    logic        packet_error;
    logic [1:0]  err_code;
    logic        busy;

    modport master (
        output rx_valid, rx_data,
        input  data_out, packet_valid, packet_error, err_code, busy
    );

    modport slave (
        input  rx_valid, rx_data,
        output data_out, packet_valid, packet_error, err_code, busy
    );
endinterface

// File: rtl/receive_control.sv
// Assembles 8-byte packets (start, id, func, 3 payload, end, xor-crc) from a
// byte strobe stream, with end-byte, checksum and inter-byte timeout checking.
module receive_control #(
    parameter logic [7:0]  START_BYTE     = 8'h11,
    parameter logic [7:0]  END_BYTE       = 8'h11,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic clk,
    input logic rst,
    receive_control_if.slave bus
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] GAP_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, ID, FUNC, PAY1, PAY2, PAY3, ENDING, CRC
    } state_t;

    state_t        state, next_state;
    logic [55:0]   pkt_buf;
    logic [7:0]    csum;
    logic [CW-1:0] gap_cnt;
    logic [63:0]   data_out_q;
    logic          packet_valid_q;
    logic          packet_error_q;
    logic [1:0]    err_code_q;

    logic          load_start;
    logic          load_byte;
    logic          accept;
    logic          discard;
    logic [1:0]    err_next;
    logic          timeout;

    assign timeout = (gap_cnt == GAP_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_comb begin
        next_state = state;
        load_start = 1'b0;
        load_byte  = 1'b0;
        accept     = 1'b0;
        discard    = 1'b0;
        err_next   = 2'b00;
        case (state)
            IDLE: begin
                if (bus.rx_valid && bus.rx_data == START_BYTE) begin
                    load_start = 1'b1;
                    next_state = ID;
                end
            end
            ID, FUNC, PAY1, PAY2, PAY3: begin
                if (bus.rx_valid) begin
                    load_byte = 1'b1;
                    case (state)
                        ID:      next_state = FUNC;
                        FUNC:    next_state = PAY1;
                        PAY1:    next_state = PAY2;
                        PAY2:    next_state = PAY3;
                        default: next_state = ENDING;
                    endcase
                end else if (timeout) begin
                    discard    = 1'b1;
                    err_next   = 2'b11;
                    next_state = IDLE;
                end
            end
            ENDING: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data == END_BYTE) begin
                        load_byte  = 1'b1;
                        next_state = CRC;
                    end else begin
                        discard    = 1'b1;
                        err_next   = 2'b01;
                        next_state = IDLE;
                    end
                end else if (timeout) begin
                    discard    = 1'b1;
                    err_next   = 2'b11;
                    next_state = IDLE;
                end
            end
            CRC: begin
                if (bus.rx_valid) begin
                    next_state = IDLE;
                    if (bus.rx_data == csum) begin
                        accept = 1'b1;
                    end else begin
                        discard  = 1'b1;
                        err_next = 2'b10;
                    end
                end else if (timeout) begin
                    discard    = 1'b1;
                    err_next   = 2'b11;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_buf        <= '0;
            csum           <= '0;
            gap_cnt        <= '0;
            data_out_q     <= '0;
            packet_valid_q <= 1'b0;
            packet_error_q <= 1'b0;
            err_code_q     <= 2'b00;
        end else begin
            gap_cnt        <= (bus.rx_valid || next_state == IDLE) ? '0 : gap_cnt + 1'b1;
            packet_valid_q <= accept;
            packet_error_q <= discard;
            if (discard) err_code_q <= err_next;
            if (accept)  data_out_q <= {pkt_buf, bus.rx_data};
            // Bytes shift in from the bottom so byte 0 lands at [55:48] after seven loads.
            if (load_start) begin
                pkt_buf <= {pkt_buf[47:0], bus.rx_data};
                csum    <= bus.rx_data;
            end else if (load_byte) begin
                pkt_buf <= {pkt_buf[47:0], bus.rx_data};
                csum    <= csum ^ bus.rx_data;
            end
        end
    end

    assign bus.data_out     = data_out_q;
    assign bus.packet_valid = packet_valid_q;
    assign bus.packet_error = packet_error_q;
    assign bus.err_code     = err_code_q;
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_receive_control.sv
// Directed self-checking bench for receive_control with a short timeout.
module tb_receive_control;
    localparam int unsigned TMO = 20;
    localparam logic [63:0] PKT_A = 64'h110100FFEAFF11EB;
    localparam logic [63:0] PKT_B = 64'h1102030405061106;

    logic clk;
    logic rst;
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned pv_cnt = 0;
    int unsigned pe_cnt = 0;
    int unsigned both_cnt = 0;

    receive_control_if bus ();

    receive_control #(
        .START_BYTE    (8'h11),
        .END_BYTE      (8'h11),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.packet_valid) pv_cnt++;
            if (bus.packet_error) pe_cnt++;
            if (bus.packet_valid && bus.packet_error) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    // Sends the first n bytes of p, most significant first, with gap idle cycles between.
    task automatic send_bytes(input logic [63:0] p, input int unsigned n, input int unsigned gap);
        for (int unsigned i = 0; i < n; i++) begin
            send_byte(p[63 - 8*i -: 8]);
            if (i + 1 < n) idle(gap);
        end
    endtask

    task automatic check_outs(input string tag, input logic [63:0] d, input logic pv,
                              input logic pe, input logic [1:0] ec, input logic bz);
        check({tag, ".data"}, bus.data_out, d);
        check({tag, ".pv"}, {63'b0, bus.packet_valid}, {63'b0, pv});
        check({tag, ".pe"}, {63'b0, bus.packet_error}, {63'b0, pe});
        check({tag, ".err"}, {62'b0, bus.err_code}, {62'b0, ec});
        check({tag, ".busy"}, {63'b0, bus.busy}, {63'b0, bz});
    endtask

    initial begin
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #1;
        check_outs("reset", 64'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        #21 rst = 1'b0;
        @(posedge clk);
        #1;

        // Good packet, bytes 10 cycles apart
        send_bytes(PKT_A, 7, 9);
        idle(9);
        check_outs("good_pre", 64'h0, 1'b0, 1'b0, 2'b00, 1'b1);
        send_byte(8'hEB);
        check_outs("good", PKT_A, 1'b1, 1'b0, 2'b00, 1'b0);
        idle(1);
        check("good_pulse_end", {63'b0, bus.packet_valid}, 64'h0);

        // Bad CRC, then a start byte in the error-pulse cycle
        send_bytes(64'h110100FFEAFF1152, 8, 0);
        check_outs("badcrc", PKT_A, 1'b0, 1'b1, 2'b10, 1'b0);
        send_bytes(PKT_B, 8, 0);
        check_outs("after_err", PKT_B, 1'b1, 1'b0, 2'b10, 1'b0);

        // Bad end byte; trailing crc byte ignored in IDLE
        send_bytes(64'h110100FFEAFF2200, 7, 0);
        check_outs("badend", PKT_B, 1'b0, 1'b1, 2'b01, 1'b0);
        send_byte(8'hEB);
        check_outs("badend_crc", PKT_B, 1'b0, 1'b0, 2'b01, 1'b0);

        // Timeout after byte 1
        send_bytes(PKT_A, 2, 0);
        idle(TMO - 1);
        check_outs("tmo_pre", PKT_B, 1'b0, 1'b0, 2'b01, 1'b1);
        idle(1);
        check_outs("tmo", PKT_B, 1'b0, 1'b1, 2'b11, 1'b0);

        // Byte on the expiry cycle wins over the timeout
        send_bytes(PKT_A, 2, 0);
        idle(TMO - 1);
        send_byte(8'h00);
        check_outs("tmo_race", PKT_B, 1'b0, 1'b0, 2'b11, 1'b1);
        send_bytes(64'hFFEAFF11EB000000, 5, 0);
        check_outs("tmo_race_pkt", PKT_A, 1'b1, 1'b0, 2'b11, 1'b0);

        // Two packets on 16 consecutive cycles
        send_bytes(PKT_A, 8, 0);
        check_outs("b2b_1", PKT_A, 1'b1, 1'b0, 2'b11, 1'b0);
        send_bytes(PKT_B, 8, 0);
        check_outs("b2b_2", PKT_B, 1'b1, 1'b0, 2'b11, 1'b0);
        idle(2);

        // Leading junk, then a good packet
        send_bytes(64'h0055000000000000, 2, 0);
        check_outs("junk", PKT_B, 1'b0, 1'b0, 2'b11, 1'b0);
        send_bytes(PKT_A, 8, 0);
        check_outs("after_junk", PKT_A, 1'b1, 1'b0, 2'b11, 1'b0);

        // Reset mid-packet: outputs clear before any clock edge
        send_bytes(PKT_B, 4, 0);
        check("mid_busy", {63'b0, bus.busy}, 64'h1);
        #2 rst = 1'b1;
        #1;
        check_outs("mid_rst", 64'h0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle(TMO + 4);
        check_outs("post_rst", 64'h0, 1'b0, 1'b0, 2'b00, 1'b0);

        check("pv_count", 64'(pv_cnt), 64'd6);
        check("pe_count", 64'(pe_cnt), 64'd3);
        check("pv_pe_overlap", 64'(both_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
